// File: rtl/lcd_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_ctrl
// Function : Write-only SPI master (mode 3, MSB first) for the EADOGS102N-6
//            LCD. One byte plus a command/data flag per start/ready handshake.
// Options  : LCD_SPI_BURST_EN - chain bytes inside one CS-low window.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_ctrl #(
    parameter int CLK_DIV = 4          // sysclk cycles per SCK half-period, 2..255
) (
    input  logic       i_sysclk,
    input  logic       i_sysrst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_cd,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_cs_n,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_cd
);

    localparam int            CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
`ifdef LCD_SPI_BURST_EN
    // Ready must be visible during the final HOLD cycle, so it is raised one
    // cycle early.
    localparam logic [CW-1:0] LAST_M1 = CW'(CLK_DIV - 2);
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] half_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          ready;
    logic          busy;
    logic          done;
    logic          cs_n;
    logic          sck;
    logic          cd;

    wire phase_end = (half_cnt == LAST);

    // Frame sequencer: state, counters, shift register and all bus outputs.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            state    <= ST_IDLE;
            half_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs_n     <= 1'b1;
            sck      <= 1'b1;
            cd       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        shreg    <= i_data;
                        cd       <= i_cd;
                        bit_cnt  <= 3'd0;
                        half_cnt <= '0;
                        state    <= ST_SETUP;
                        cs_n     <= 1'b0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        half_cnt <= '0;
                        state    <= ST_LOW;
                        sck      <= 1'b0;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        half_cnt <= '0;
                        state    <= ST_HIGH;
                        sck      <= 1'b1;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        half_cnt <= '0;
                        if (bit_cnt != 3'd7) begin
                            // Next bit appears together with the SCK falling edge.
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= ST_LOW;
                            sck     <= 1'b0;
                        end else begin
                            state   <= ST_HOLD;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (phase_end) begin
                        half_cnt <= '0;
                        done     <= 1'b1;
                        ready    <= 1'b0;
`ifdef LCD_SPI_BURST_EN
                        if (i_start) begin
                            // Chain the next byte: CS stays low, no SETUP/GAP.
                            shreg   <= i_data;
                            cd      <= i_cd;
                            bit_cnt <= 3'd0;
                            state   <= ST_LOW;
                            sck     <= 1'b0;
                        end else begin
                            state   <= ST_GAP;
                            cs_n    <= 1'b1;
                            busy    <= 1'b0;
                        end
`else
                        state    <= ST_GAP;
                        cs_n     <= 1'b1;
                        busy     <= 1'b0;
`endif
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
`ifdef LCD_SPI_BURST_EN
                        if (half_cnt == LAST_M1) begin
                            ready <= 1'b1;
                        end
`endif
                    end
                end
                ST_GAP: begin
                    if (phase_end) begin
                        half_cnt <= '0;
                        state    <= ST_IDLE;
                        ready    <= 1'b1;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    half_cnt <= '0;
                    ready    <= 1'b1;
                    busy     <= 1'b0;
                    cs_n     <= 1'b1;
                    sck      <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = ready;
    assign o_busy  = busy;
    assign o_done  = done;
    assign o_cs_n  = cs_n;
    assign o_sck   = sck;
    assign o_mosi  = shreg[7];
    assign o_cd    = cd;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_spi_ctrl
// Function : Directed self-checking bench for lcd_spi_ctrl (CLK_DIV=4) with
//            an LCD-side sampler on SCK rising edges.
// Options  : LCD_SPI_BURST_EN selects the burst-mode scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_ctrl;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       cd_in = 1'b0;
    logic       ready, busy, done, cs_n, sck, mosi, cd_out;

    lcd_spi_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .i_sysclk (clk),
        .i_sysrst (rst),
        .i_start  (start),
        .i_data   (data),
        .i_cd     (cd_in),
        .o_ready  (ready),
        .o_busy   (busy),
        .o_done   (done),
        .o_cs_n   (cs_n),
        .o_sck    (sck),
        .o_mosi   (mosi),
        .o_cd     (cd_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // LCD-side model: samples MOSI/CD on SCK rising edges while CS is low.
    logic       prev_sck = 1'b1;
    logic       prev_cs  = 1'b1;
    logic [7:0] rx_byte  = 8'h00;
    int         rx_bits  = 0;
    logic [8:0] rxq[$];
    int rises = 0, falls = 0, windows = 0, done_cnt = 0;
    int high_run = 0, last_gap = 0, cyc = 0, done_prev = 0, done_last = 0;

    always @(negedge clk) begin
        cyc++;
        if (sck && !prev_sck) begin
            rises++;
            if (!cs_n) begin
                rx_byte = {rx_byte[6:0], mosi};
                rx_bits++;
                if (rx_bits == 8) begin
                    rxq.push_back({cd_out, rx_byte});
                    rx_bits = 0;
                end
            end
        end
        if (!sck && prev_sck) falls++;
        if (cs_n) rx_bits = 0;
        if (!cs_n && prev_cs) begin
            windows++;
            last_gap = high_run;
        end
        if (cs_n) high_run++; else high_run = 0;
        if (done) begin
            done_cnt++;
            done_prev = done_last;
            done_last = cyc;
        end
        prev_sck = sck;
        prev_cs  = cs_n;
    end

    // Waits for ready, presents one byte, returns at the negedge of cycle 1.
    task automatic send(input logic [7:0] d, input logic c);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
        start = 1'b1;
        data  = d;
        cd_in = c;
        @(negedge clk);
        start = 1'b0;
        data  = ~d;
        cd_in = ~c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_rx(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = 9'h1FF;
        if (rxq.size() > 0) got = rxq.pop_front();
        check(tag, {23'd0, got}, {23'd0, exp});
    endtask

    initial begin
        int dcyc, rcyc, d0, w0, r0, f0, q0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_cs_n",  {31'd0, cs_n},   32'd1);
        check("rst_sck",   {31'd0, sck},    32'd1);
        check("rst_mosi",  {31'd0, mosi},   32'd0);
        check("rst_cd",    {31'd0, cd_out}, 32'd0);
        check("rst_busy",  {31'd0, busy},   32'd0);
        check("rst_done",  {31'd0, done},   32'd0);
        check("rst_ready", {31'd0, ready},  32'd1);
        rst = 1'b0;
        idle(20);
        check("idle_done_cnt", done_cnt, 0);
        check("idle_windows",  windows,  0);
        check("idle_ready",    {31'd0, ready}, 32'd1);
        check("idle_sck",      {31'd0, sck},   32'd1);

        // 0xA5, cd=0: cycle-accurate frame timing
        r0 = rises; f0 = falls;
        send(8'hA5, 1'b0);
        check("a5_c1_cs_n", {31'd0, cs_n},  32'd0);
        check("a5_c1_mosi", {31'd0, mosi},  32'd1);
        check("a5_c1_sck",  {31'd0, sck},   32'd1);
        check("a5_c1_busy", {31'd0, busy},  32'd1);
        check("a5_c1_rdy",  {31'd0, ready}, 32'd0);
        dcyc = -1; rcyc = -1;
        for (int k = 1; k <= 90; k++) begin
            if (k > 1) @(negedge clk);
            if (k == CLK_DIV + 1) check("a5_first_fall", {31'd0, sck}, 32'd0);
            if (k == 73) check("a5_cs_rise_sck", {31'd0, sck}, 32'd1);
            if (done && dcyc < 0) dcyc = k;
            if (ready && rcyc < 0) rcyc = k;
        end
        check("a5_done_cycle", dcyc, 73);
`ifdef LCD_SPI_BURST_EN
        check("a5_ready_cycle", rcyc, 72);
`else
        check("a5_ready_cycle", rcyc, 77);
`endif
        check("a5_rises", rises - r0, 8);
        check("a5_falls", falls - f0, 8);
        check_rx("a5_rx", {1'b0, 8'hA5});

        // 0x3C, cd=1 with spurious i_start pulses mid-frame
        d0 = done_cnt; w0 = windows; q0 = rxq.size();
        send(8'h3C, 1'b1);
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 10 || k == 50) begin start = 1'b1; data = 8'hFF; cd_in = 1'b0; end
            else start = 1'b0;
        end
        check("3c_done_once", done_cnt - d0, 1);
        check("3c_one_window", windows - w0, 1);
        check("3c_rx_count", rxq.size() - q0, 1);
        check_rx("3c_rx", {1'b1, 8'h3C});

        // Reset in the middle of a frame
        d0 = done_cnt; q0 = rxq.size();
        send(8'hC3, 1'b1);
        for (int k = 2; k <= 30; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cs_n",  {31'd0, cs_n},  32'd1);
        check("mid_rst_sck",   {31'd0, sck},   32'd1);
        check("mid_rst_busy",  {31'd0, busy},  32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        idle(100);
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_no_rx", rxq.size() - q0, 0);
        send(8'h5A, 1'b0);
        idle(90);
        check("post_rst_done", done_cnt - d0, 1);
        check_rx("post_rst_rx", {1'b0, 8'h5A});

`ifdef LCD_SPI_BURST_EN
        // Burst: 0x81 (cd=0) chained with 0x7E (cd=1), start held high
        d0 = done_cnt; w0 = windows; r0 = rises;
        begin
            int w;
            w = 0;
            @(negedge clk);
            start = 1'b1; data = 8'h81; cd_in = 1'b0;
            @(negedge clk);
            data = 8'h7E; cd_in = 1'b1;
            while (!ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!ready) check("burst_ready_timeout", 32'd0, 32'd1);
            @(negedge clk);
            start = 1'b0;
        end
        idle(150);
        check("burst_one_window", windows - w0, 1);
        check("burst_rises", rises - r0, 16);
        check("burst_done_cnt", done_cnt - d0, 2);
        check("burst_done_gap", done_last - done_prev, 68);
        check_rx("burst_rx0", {1'b0, 8'h81});
        check_rx("burst_rx1", {1'b1, 8'h7E});
`else
        // Back-to-back framed bytes
        w0 = windows;
        send(8'h00, 1'b0);
        send(8'hFF, 1'b1);
        check("b2b_gap_min", (last_gap >= CLK_DIV) ? 32'd1 : 32'd0, 32'd1);
        idle(90);
        check("b2b_windows", windows - w0, 2);
        check_rx("b2b_rx0", {1'b0, 8'h00});
        check_rx("b2b_rx1", {1'b1, 8'hFF});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_spi_ctrl.md
# lcd_spi_ctrl

Write-only SPI master controller for the EADOGS102N-6 LCD path. It accepts one byte plus a command/data flag over a start/ready handshake. It sequences an internal 8-bit MSB-first load/shift register and generates the chip select, serial clock, data and CD lines. It sits between the display-update logic and the LCD pins, and is the only block that drives the SPI bus.

## Interface
- CLK_DIV, 4: system clock cycles per SCK half-period; legal range 2..255.
- i_sysclk  input  1  system clock; all logic on its rising edge.
- i_sysrst  input  1  reset; one clock, synchronous, active-high.
- i_start  input  1  transfer request; accepted only on a cycle with o_ready=1.
- i_data  input  8  byte to send; captured on the accept edge.
- i_cd  input  1  0 = command, 1 = display data; captured on the accept edge.
- o_ready  output  1  controller can accept i_start this cycle.
- o_busy  output  1  transfer in progress, from the accept edge until o_done.
- o_done  output  1  one-cycle pulse when a byte has been fully shifted out.
- o_cs_n  output  1  LCD chip select, active low.
- o_sck  output  1  SPI clock; idles high (mode 3).
- o_mosi  output  1  serial data, MSB first; equals bit 7 of the internal shift register.
- o_cd  output  1  LCD CD line; held for the whole frame.

## Operation
- Reset values:
  - o_cs_n=1, o_sck=1, o_mosi=0, o_cd=0, o_busy=0, o_done=0, o_ready=1.
  - Shift register = 0x00, state = IDLE.
- Internal shift register:
  - Load has priority over shift.
  - Shift moves the register left with 0 entering at the LSB.
- States:
  - IDLE: accepting i_start loads i_data into the shift register, latches i_cd, and goes to SETUP.
  - SETUP: CS low, SCK high, for CLK_DIV cycles. Then goes to LOW.
  - LOW: SCK low for CLK_DIV cycles. Then goes to HIGH.
  - HIGH: SCK high for CLK_DIV cycles. At the end, if the bit counter < 7, shift the register, increment the counter and go to LOW; otherwise go to HOLD.
  - HOLD: CS low, SCK high, for CLK_DIV cycles.
  - GAP: CS high, for CLK_DIV cycles. o_done pulses in the first GAP cycle. Then goes to IDLE.
- Bus timing:
  - MOSI changes only on SCK falling edges or in SETUP.
  - The LCD samples on SCK rising edges.
- Bit counter: 3 bits, cleared on load.
- Half-period counter: width clog2(CLK_DIV); reloads at each state change and never wraps mid-phase.
- o_ready=1 only in IDLE. o_busy=1 in SETUP, LOW, HIGH and HOLD.
- i_start while o_ready=0 is ignored; it is neither queued nor an error.
- i_data and i_cd may change freely after the accept edge.
- Reset mid-transfer: the next cycle shows the reset values, no o_done pulse, and the byte is dropped.
- Reset takes priority over i_start on the same edge.

## Timing
- Accept edge = cycle 0.
- o_cs_n falls and o_mosi = bit 7 in cycle 1.
- First SCK falling edge: cycle CLK_DIV+1.
- Bit n rising edge: cycle (2n+2)·CLK_DIV+1.
- o_cs_n rises and o_done=1 in cycle 18·CLK_DIV+1 (73 for CLK_DIV=4).
- o_ready returns in cycle 19·CLK_DIV+1 (77 for CLK_DIV=4).
- Exactly 8 SCK falling and 8 rising edges per frame.
- SCK is high when CS falls and when CS rises.

## Configuration
- LCD_SPI_BURST_EN defined:
  - o_ready is also 1 in the last HOLD cycle.
  - An i_start accepted there loads the new byte and cd, and goes straight to LOW.
  - CS stays low, with no SETUP or GAP.
  - o_done pulses in the first cycle of the new LOW phase, and o_busy stays 1.
  - Back-to-back frames are 17·CLK_DIV cycles apart.
  - A cd change between bytes takes effect in that same first cycle of LOW.
- LCD_SPI_BURST_EN undefined: every byte is framed by its own CS low period followed by a CLK_DIV-cycle GAP.

## Test plan
- Reset, then idle 20 cycles -> o_cs_n=1, o_sck=1, o_ready=1, o_done never pulses.
- CLK_DIV=4, send 0xA5 with cd=0 -> LCD-side sampler on SCK rising edges reads 10100101 and cd=0. o_done in cycle 73, o_ready in cycle 77.
- Send 0x3C with cd=1; pulse i_start again at cycles 10 and 50 -> only one frame sent and o_done pulses once.
- Start a frame; assert i_sysrst at cycle 30 -> cycle 31 shows o_cs_n=1, o_sck=1, o_busy=0. No o_done; the next frame is sent normally.
- With the macro undefined, send 0x00 then 0xFF as fast as o_ready allows -> two CS-low windows separated by at least 4 CS-high cycles. The bytes read back as 0x00 and 0xFF.
- With LCD_SPI_BURST_EN, send 0x81 then 0x7E (cd 0 then 1) with i_start held high -> a single CS-low window of 16 SCK pulses. The bytes read back as 0x81 and 0x7E, the second byte sampled with cd=1. The two o_done pulses are 68 cycles apart.
